nibble_capture_buf: RTL and testbench

- Downstream consumer of the 4-bit serial-in shift stage, which shifts x into q[3] every clk, toward q[0].
- Counts qualified serial bits and snapshots the shifter's parallel q after each complete 4-bit group.
- Pushes each captured nibble into a small synchronous FIFO.
- Presents nibbles on a valid/ready interface to the next stage.

---
 rtl/nibble_pkg.sv | 15 +
 rtl/nibble_capture_buf_if.sv | 40 ++++
 rtl/sync_fifo_nib.sv | 73 +++++++
 rtl/nibble_capture_buf.sv | 75 +++++++
 tb/tb_nibble_capture_buf.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble capture buffer.
// Holds the nibble width, the serial bit-counter width, the default FIFO depth
// and the nibble type used by the top level, the FIFO and the interface.
package nibble_pkg;

    localparam int NIB_W         = 4;
    localparam int BITCNT_W      = 2;
    localparam int DEFAULT_DEPTH = 4;

    // Counter value of the edge that registers the fourth bit of a nibble.
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(NIB_W - 1);

    typedef logic [NIB_W-1:0] nibble_t;

endpackage

// File: rtl/nibble_capture_buf_if.sv
// Bus interface of the nibble capture buffer.
// Carries the serial qualifiers and shifter snapshot into the block, and the
// output nibble stream plus status back out.
//   bit_en, sync, shift_q, ovf_clr : producer side -> buffer
//   out_data, out_valid            : buffer -> consumer
//   out_ready                      : consumer -> buffer
//   level, overflow                : buffer status
// Handshake: a nibble moves on every rising clk edge where out_valid and
// out_ready are both high. out_valid never depends on out_ready, and while
// out_valid is high and out_ready is low, out_data is held stable.
interface nibble_capture_buf_if
    import nibble_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) ();

    logic             bit_en;
    logic             sync;
    nibble_t          shift_q;
    logic             out_ready;
    logic             ovf_clr;
    nibble_t          out_data;
    logic             out_valid;
    logic [CNT_W-1:0] level;
    logic             overflow;

    // Environment side: drives the serial qualifiers and consumes nibbles.
    modport master (
        output bit_en, sync, shift_q, out_ready, ovf_clr,
        input  out_data, out_valid, level, overflow
    );

    // Buffer side.
    modport slave (
        input  bit_en, sync, shift_q, out_ready, ovf_clr,
        output out_data, out_valid, level, overflow
    );

endinterface

// File: rtl/sync_fifo_nib.sv
// Synchronous nibble FIFO with registered storage and no fall-through.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-low reset (clears pointers, count and storage)
//   push  : write din this edge (ignored when full unless a pop happens too)
//   din   : nibble to write
//   pop   : remove the head this edge (ignored when empty)
//   dout  : head entry, taken straight from the storage registers
//   full  : count == DEPTH
//   empty : count == 0
//   level : occupancy, 0..DEPTH
module sync_fifo_nib
    import nibble_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  nibble_t          din,
    input  logic             pop,
    output nibble_t          dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    nibble_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is still accepted when the head leaves on the
    // same edge, so occupancy stays at DEPTH.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/nibble_capture_buf.sv
// Nibble capture buffer: counts contiguous qualified serial bits, snapshots the
// upstream 4-bit shifter after each complete group and queues the nibble.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : nibble_capture_buf_if.slave (serial qualifiers, shifter snapshot,
//         output stream with valid/ready, level and sticky overflow)
module nibble_capture_buf
    import nibble_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    nibble_capture_buf_if.slave bus
);

    logic [BITCNT_W-1:0] bit_cnt;
    logic                cap_pend;
    logic                overflow_q;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_level;
    logic                drop;

    // A full FIFO always has a head, so out_ready alone decides whether the
    // pending nibble finds room this edge.
    assign drop = cap_pend & fifo_full & ~bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt    <= '0;
            cap_pend   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // The shifter has moved b0..b3 into q[0]..q[3] by the edge after
            // the fourth bit, so the push is deferred by one cycle.
            cap_pend <= bus.bit_en & ~bus.sync & (bit_cnt == LAST_BIT);

            if (bus.sync) begin
                // Frame start; a bit arriving with sync is the new bit 1.
                bit_cnt <= bus.bit_en ? BITCNT_W'(1) : '0;
            end else if (bus.bit_en) begin
                bit_cnt <= bit_cnt + 1'b1;  // wraps to 0 after the 4th bit
            end else begin
                // The shifter cannot hold, so a gap ruins the partial nibble.
                bit_cnt <= '0;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    sync_fifo_nib #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap_pend),
        .din   (bus.shift_q),
        .pop   (bus.out_ready),
        .dout  (bus.out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bus.out_valid = ~fifo_empty;
    assign bus.level     = fifo_level;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_capture_buf.sv
// Directed bench for nibble_capture_buf: a serial shifter feeds the block, a
// queue-based model predicts every output each cycle, and literal checks pin
// the key scenarios.
module tb_nibble_capture_buf;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x   = 1'b0;
    logic [3:0] sh_q = 4'h0;
    logic       cmp_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_capture_buf_if #(.DEPTH(DEPTH)) bus ();

    nibble_capture_buf #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Upstream serial-in shifter: x enters q[3] and moves toward q[0].
    always @(posedge clk) sh_q <= {x, sh_q[3:1]};
    assign bus.shift_q = sh_q;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] exp_q[$];
    logic       m_bits[$];
    bit         m_pend;
    logic [3:0] m_pend_val;
    bit         m_ovf;
    bit         m_pop;
    bit         m_drop;

    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_bits.delete();
            m_pend = 0;
            m_ovf  = 0;
        end else begin
            m_pop  = (exp_q.size() != 0) && bus.out_ready;
            m_drop = 0;
            if (m_pop) void'(exp_q.pop_front());
            if (m_pend) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(m_pend_val);
                else m_drop = 1;
            end
            if (bus.ovf_clr) m_ovf = 0;
            if (m_drop) m_ovf = 1;
            m_pend = 0;
            if (bus.sync || !bus.bit_en) m_bits.delete();
            if (bus.bit_en) m_bits.push_back(x);
            if (m_bits.size() == 4) begin
                m_pend     = 1;
                m_pend_val = {m_bits[3], m_bits[2], m_bits[1], m_bits[0]};
                m_bits.delete();
            end
        end
    end

    // Compare process: outputs are registered, so the falling edge is safe.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_valid", 8'(bus.out_valid), 8'(exp_q.size() != 0));
            chk("model_level", 8'(bus.level), 8'(exp_q.size()));
            chk("model_overflow", 8'(bus.overflow), 8'(m_ovf));
            if (exp_q.size() != 0) chk("model_data", 8'(bus.out_data), 8'(exp_q[0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic be, input logic s, input logic xv,
                        input logic rdy, input logic clr);
        bus.bit_en    = be;
        bus.sync      = s;
        x             = xv;
        bus.out_ready = rdy;
        bus.ovf_clr   = clr;
        @(negedge clk);
    endtask

    task automatic send_nibble(input logic [3:0] n, input logic rdy);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, n[i], rdy, 1'b0);
    endtask

    task automatic expect_head(input string name, input logic [3:0] val);
        chk({name, "_valid"}, 8'(bus.out_valid), 8'd1);
        chk({name, "_data"}, 8'(bus.out_data), 8'(val));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.bit_en = 1'b0; bus.sync = 1'b0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_level", 8'(bus.level), 8'd0);
        chk("reset_valid", 8'(bus.out_valid), 8'd0);
        chk("reset_overflow", 8'(bus.overflow), 8'd0);
        chk("reset_data", 8'(bus.out_data), 8'd0);
        rst = 1'b1;
        cmp_en = 1'b1;

        // Serial 1,0,1,1 -> 4'b1101, visible for one cycle two edges later.
        send_nibble(4'b1101, 1'b1);
        chk("t1_not_yet", 8'(bus.out_valid), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_valid", 8'(bus.out_valid), 8'd1);
        chk("t1_data", 8'(bus.out_data), 8'hD);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_gone", 8'(bus.out_valid), 8'd0);

        // Fill: 16 continuous bits, then one more nibble whose push fills level 4.
        send_nibble(4'h1, 1'b0);
        send_nibble(4'h2, 1'b0);
        send_nibble(4'h3, 1'b0);
        send_nibble(4'h4, 1'b0);
        send_nibble(4'h5, 1'b0);
        chk("t2_full_level", 8'(bus.level), 8'd4);
        chk("t2_no_ovf", 8'(bus.overflow), 8'd0);
        // Push of 5 meets a pop of 1 while full.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_level", 8'(bus.level), 8'd4);
        chk("t3_no_ovf", 8'(bus.overflow), 8'd0);
        chk("t3_head", 8'(bus.out_data), 8'h2);
        // Nibble 6 is dropped; clear in the same cycle loses to the set.
        send_nibble(4'h6, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_set_wins", 8'(bus.overflow), 8'd1);
        chk("t6_level", 8'(bus.level), 8'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_cleared", 8'(bus.overflow), 8'd0);
        expect_head("drain0", 4'h2);
        expect_head("drain1", 4'h3);
        expect_head("drain2", 4'h4);
        expect_head("drain3", 4'h5);
        chk("drain_empty", 8'(bus.out_valid), 8'd0);
        chk("drain_level", 8'(bus.level), 8'd0);
        // Empty with out_ready high must not underflow.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("no_underflow", 8'(bus.level), 8'd0);

        // Partial nibble broken by an idle cycle.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_nibble(4'b0110, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_gap_level", 8'(bus.level), 8'd1);
        chk("t4_gap_data", 8'(bus.out_data), 8'h6);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Partial nibble broken by sync; the sync cycle carries bit 0 = 0.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_sync_level", 8'(bus.level), 8'd1);
        chk("t4_sync_data", 8'(bus.out_data), 8'h6);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset with level 2 and a capture pending.
        send_nibble(4'h3, 1'b0);
        send_nibble(4'h9, 1'b0);
        send_nibble(4'hA, 1'b0);
        chk("t5_pre_level", 8'(bus.level), 8'd2);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        chk("t5_level", 8'(bus.level), 8'd0);
        chk("t5_valid", 8'(bus.out_valid), 8'd0);
        chk("t5_overflow", 8'(bus.overflow), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_no_push", 8'(bus.level), 8'd0);

        // Fresh nibble after reset behaves normally.
        send_nibble(4'hC, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_data", 8'(bus.out_data), 8'hC);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
